rx_gearbox_lock: RTL and testbench
==================================

# rx_gearbox_lock

Receive-side counterpart of `tx_gearbox`. It sits between the PMA receive data bus and the descrambler. It converts the free-running PMA_WIDTH-bit receive stream into 66-bit blocks and hunts for the 2-bit sync-header alignment by bit-slipping. It maintains block lock with an 802.3-style good/bad header window and forwards only blocks received while locked.

## Interface
Parameters:
- `PMA_WIDTH`, default 32: receive bus width in bits; legal range 16..64.
- `LOCK_CNT`, default 64: consecutive valid headers needed to declare lock; also the size of the locked-state monitoring window.
- `BAD_MAX`, default 16: number of invalid headers within one window that drops lock.

Ports:
- `clk`, in, 1: PMA receive clock (clkpma_rx domain).
- `reset`, in, 1: asynchronous, active-high reset.
- `in_enable`, in, 1: lane enable. When low, the block behaves as if held in reset, synchronously.
- `in_pma_ready`, in, 1: SerDes receive ready.
- `in_valid`, in, 1: `in_data` is valid this cycle.
- `in_data`, in, PMA_WIDTH: receive bits; bit 0 is received first.
- `out_valid`, out, 1: `out_block` is valid; pulses for one cycle.
- `out_block`, out, 66: `[1:0]` is the header, `[65:2]` is the payload; bit 0 is received first.
- `out_block_lock`, out, 1: block lock status.
- `out_slip_cnt`, out, 8: saturating count of slips since reset, for debug.

## Operation
- Bit buffer `buf` is 2*66 bits wide. Fill count `cnt` ranges 0..(65+PMA_WIDTH); new bits append above `cnt`.
- Per cycle:
  - `avail = cnt + (in_valid ? PMA_WIDTH : 0)`.
  - `need = 66 + slip_pend`.
  - If `avail >= need`: extract bits `[slip_pend +: 66]`, remove `need` bits, clear `slip_pend`.
  - At most one extraction per cycle.
- Header check: `hdr = blk[1:0]`. Valid iff `hdr` is 2'b01 or 2'b10.
- FSM states:
  - **HUNT** (`out_block_lock` = 0):
    - Valid header: `good_cnt++`.
    - Invalid header: set `slip_pend`, `good_cnt = 0`, `out_slip_cnt++` (saturating).
    - When `good_cnt` reaches LOCK_CNT: go to LOCKED with `win_cnt = bad_cnt = 0`.
  - **LOCKED** (`out_block_lock` = 1):
    - Each extracted header: `win_cnt++`; invalid header also does `bad_cnt++`.
    - If `bad_cnt` reaches BAD_MAX: set `slip_pend`, `out_slip_cnt++`, go to HUNT with `good_cnt = 0`.
    - Else if `win_cnt` reaches LOCK_CNT: clear `win_cnt` and `bad_cnt`, stay in LOCKED.
- `out_valid` is asserted only for blocks extracted while the pre-update state is LOCKED. Blocks with invalid headers are still forwarded; the deescaper flags them.
- The block that completes lock is not forwarded. The block that causes loss of lock is forwarded.
- If `in_pma_ready` or `in_enable` is low: go to HUNT, set `cnt = 0`, clear all counters and `slip_pend`, suppress extraction. `out_slip_cnt` is held.
- Counter widths: `$clog2(LOCK_CNT+1)`.

## Timing
- Reset values: `out_valid` 0, `out_block` 0, `out_block_lock` 0, `out_slip_cnt` 0, `cnt` 0, FSM in HUNT.
- Latency: one cycle. A block whose last bit arrives in `in_data` at cycle t appears on `out_block`/`out_valid` at t+1.
- `out_block_lock` updates in the same cycle as the extraction that changes state takes effect, so it rises at t+1 of the LOCK_CNT-th good header.
- Throughput at PMA_WIDTH=32 with continuous `in_valid`: exactly 16 blocks per 33 input words.
- `in_valid` gaps stall extraction only; no bits are lost.
- A slip removes exactly one extra bit at the next extraction.
- Reset asserted mid-block discards the partial buffer.
- Slip request and `in_pma_ready` drop in the same cycle: the drop wins.

## Structure
- Shared package `pcs_pkg`: `BLOCK_W` = 66, header codes `HDR_DATA` = 2'b01 and `HDR_CTRL` = 2'b10, FSM state enum {HUNT, LOCKED}.
- One sub-module, `rx_lock_fsm`: header evaluation, the three counters, and slip/lock generation. The bit buffer and extraction stay in the top.

## Test plan
- Reset: hold `reset`=1 while driving data → all outputs 0. Release, then feed an aligned stream of 64 blocks with header 01 and payload 64'h0123456789ABCDEF → `out_block_lock` rises after the 64th block; first `out_valid` is the 65th block; `out_block` = {payload, 2'b01}.
- Throughput: aligned stream, continuous `in_valid`, 330 words → exactly 160 extractions, and `cnt` returns to 0.
- Misalignment: stream pre-shifted by 17 bits with a PRBS31 payload → `out_slip_cnt` ≥ 1, lock achieved, and every forwarded block matches the transmitted block.
- Errors while locked: inject 15 header errors (2'b00) into one 64-block window → lock held. Inject 16 → lock drops at the 16th and `out_slip_cnt` increments by 1.
- Flow and ready: toggle `in_valid` randomly 50% → block content unchanged. Deassert `in_pma_ready` for one cycle while locked → lock 0 the next cycle and `cnt` 0.
- Async reset mid-stream: pulse `reset` between clock edges → outputs go to 0 immediately, not waiting for the next clock edge.

Source files
------------

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared PCS constants, header codes and lock FSM state type
// Contents:
//   BLOCK_W            66-bit block width (2-bit sync header + 64-bit payload)
//   HDR_DATA/HDR_CTRL  the two legal sync-header codes
//   lock_state_t       block-lock FSM states {HUNT, LOCKED}
//   hdr_valid()        true for a legal sync header
package pcs_pkg;

  localparam int BLOCK_W = 66;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/rx_gearbox_lock_if.sv
// rtl/rx_gearbox_lock_if.sv - PMA receive bus and block output bundle
// Signals:
//   in_enable, in_pma_ready  lane enable / SerDes ready (low = synchronous clear)
//   in_valid, in_data        PMA receive word, bit 0 received first
//   out_valid, out_block     66-bit block, [1:0] header, one-cycle pulse
//   out_block_lock           block lock status
//   out_slip_cnt             saturating slip counter for debug
// Modports: master drives the in_* side, slave is the gearbox.
interface rx_gearbox_lock_if
  import pcs_pkg::*;
#(
  parameter int PMA_WIDTH = 32
) ();

  logic                 in_enable;
  logic                 in_pma_ready;
  logic                 in_valid;
  logic [PMA_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic [BLOCK_W-1:0]   out_block;
  logic                 out_block_lock;
  logic [7:0]           out_slip_cnt;

  modport master (
    output in_enable, in_pma_ready, in_valid, in_data,
    input  out_valid, out_block, out_block_lock, out_slip_cnt
  );

  modport slave (
    input  in_enable, in_pma_ready, in_valid, in_data,
    output out_valid, out_block, out_block_lock, out_slip_cnt
  );

endinterface

// File: rtl/rx_lock_fsm.sv
// rtl/rx_lock_fsm.sv - sync-header evaluation and block-lock state machine
// Ports:
//   clk, reset   receive clock, async active-high reset
//   clear        synchronous return to HUNT (lane disabled or PMA not ready)
//   blk_valid    a block was extracted this cycle
//   hdr          its 2-bit sync header
//   fwd          state before this cycle's update is LOCKED
//   slip_req     the current block requests a one-bit slip
//   lock         block lock status (registered state)
//   slip_cnt     saturating count of slips, held across clear
module rx_lock_fsm
  import pcs_pkg::*;
#(
  parameter int LOCK_CNT = 64,
  parameter int BAD_MAX  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       blk_valid,
  input  logic [1:0] hdr,
  output logic       fwd,
  output logic       slip_req,
  output logic       lock,
  output logic [7:0] slip_cnt
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  lock_state_t   state_q, state_d;
  logic [CW-1:0] good_q, good_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] bad_q, bad_d;
  logic [7:0]    slip_cnt_q;
  logic          hv;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    slip_req = 1'b0;
    hv       = hdr_valid(hdr);
    if (blk_valid) begin
      case (state_q)
        HUNT: begin
          if (!hv) begin
            slip_req = 1'b1;
            good_d   = '0;
          end else if (good_q == CW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          // Comparing against the limit minus one tests the post-increment value.
          if (!hv && bad_q == CW'(BAD_MAX - 1)) begin
            slip_req = 1'b1;
            state_d  = HUNT;
            good_d   = '0;
            win_d    = '0;
            bad_d    = '0;
          end else if (win_q == CW'(LOCK_CNT - 1)) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            bad_d = bad_q + CW'(!hv);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      good_q     <= '0;
      win_q      <= '0;
      bad_q      <= '0;
      slip_cnt_q <= '0;
    end else if (clear) begin
      state_q <= HUNT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      if (slip_req && slip_cnt_q != 8'hFF) slip_cnt_q <= slip_cnt_q + 8'd1;
    end
  end

  assign fwd      = (state_q == LOCKED);
  assign lock     = (state_q == LOCKED);
  assign slip_cnt = slip_cnt_q;

endmodule

// File: rtl/rx_gearbox_lock.sv
// rtl/rx_gearbox_lock.sv - PMA-width to 66-bit receive gearbox with block lock
// Ports:
//   clk, reset  PMA receive clock, async active-high reset
//   rx          rx_gearbox_lock_if.slave: PMA word in, 66-bit block/lock/slip out
// The bit buffer and extraction live here; header checking and lock live in
// rx_lock_fsm.
module rx_gearbox_lock
  import pcs_pkg::*;
#(
  parameter int PMA_WIDTH = 32,
  parameter int LOCK_CNT  = 64,
  parameter int BAD_MAX   = 16
) (
  input  logic                clk,
  input  logic                reset,
  rx_gearbox_lock_if.slave    rx
);

  localparam int BUF_W = 2 * BLOCK_W;
  localparam int MRG_W = BUF_W + PMA_WIDTH;

  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               slip_pend_q;
  logic [MRG_W-1:0]   merged;
  logic [8:0]         avail, need;
  logic               run, extract;
  logic [BLOCK_W-1:0] blk;
  logic               fwd, slip_req, lock;
  logic [7:0]         slip_cnt;
  logic               out_valid_q;
  logic [BLOCK_W-1:0] out_block_q;

  assign run = rx.in_enable & rx.in_pma_ready;

  // Bits above cnt_q in buf_q are always zero, so a new word can be OR-ed in.
  always_comb begin
    merged = {{PMA_WIDTH{1'b0}}, buf_q};
    avail  = {1'b0, cnt_q};
    if (rx.in_valid) begin
      merged = merged | ({{BUF_W{1'b0}}, rx.in_data} << cnt_q);
      avail  = avail + 9'(PMA_WIDTH);
    end
    need    = 9'(BLOCK_W) + {8'd0, slip_pend_q};
    extract = run && (avail >= need);
    // A pending slip skips the oldest bit of this block.
    blk     = slip_pend_q ? merged[BLOCK_W:1] : merged[BLOCK_W-1:0];
    buf_d   = extract ? BUF_W'(merged >> need) : merged[BUF_W-1:0];
    cnt_d   = extract ? 8'(avail - need) : 8'(avail);
  end

  rx_lock_fsm #(
    .LOCK_CNT (LOCK_CNT),
    .BAD_MAX  (BAD_MAX)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear     (!run),
    .blk_valid (extract),
    .hdr       (blk[1:0]),
    .fwd       (fwd),
    .slip_req  (slip_req),
    .lock      (lock),
    .slip_cnt  (slip_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else if (!run) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= extract & fwd;
      if (extract) slip_pend_q <= slip_req;
      if (extract & fwd) out_block_q <= blk;
    end
  end

  assign rx.out_valid      = out_valid_q;
  assign rx.out_block      = out_block_q;
  assign rx.out_block_lock = lock;
  assign rx.out_slip_cnt   = slip_cnt;

endmodule

// File: tb/tb_rx_gearbox_lock.sv
// tb/tb_rx_gearbox_lock.sv - directed self-checking bench for rx_gearbox_lock
module tb_rx_gearbox_lock;
  import pcs_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]  hdr;
    logic [63:0] pay;
    logic [65:0] exp_blk;
    logic        exp_lock;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_gearbox_lock_if #(.PMA_WIDTH(W)) rx ();

  rx_gearbox_lock #(.PMA_WIDTH(W), .LOCK_CNT(64), .BAD_MAX(16)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx.slave)
  );

  int          vecs = 0;
  int          errs = 0;
  bit          bitq[$];
  logic [65:0] sent[$];
  int          ptr, exp_first, nvalid, nfalls;
  logic        lock_prev;
  logic [65:0] fall_blk;
  logic        fall_valid;
  logic [7:0]  fall_slip;
  logic [30:0] lfsr;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_block(input logic [1:0] hdr, input logic [63:0] pay);
    logic [65:0] b;
    b = {pay, hdr};
    sent.push_back(b);
    for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
  endtask

  function automatic bit prbs_bit();
    bit b;
    b = lfsr[30] ^ lfsr[27];
    lfsr = {lfsr[29:0], b};
    return b;
  endfunction

  task automatic drive(input int pct);
    logic [W-1:0] d;
    bit v;
    int idx;
    v = (bitq.size() >= W) && ($urandom_range(99) < pct);
    d = W'($urandom);
    if (v) for (int i = 0; i < W; i++) d[i] = bitq.pop_front();
    rx.in_valid = v;
    rx.in_data  = d;
    @(posedge clk);
    #1;
    if (rx.out_valid) begin
      nvalid++;
      if (ptr < 0) begin
        if (exp_first >= 0) begin
          check("first_fwd", rx.out_block, sent[exp_first]);
          ptr = exp_first + 1;
          exp_first = -1;
        end else begin
          idx = -1;
          for (int k = 0; k < sent.size(); k++)
            if (sent[k] === rx.out_block) begin idx = k; break; end
          vecs++;
          if (idx < 0) begin
            errs++;
            $display("FAIL fwd_search: got %h expected a transmitted block", rx.out_block);
          end else ptr = idx + 1;
        end
      end else begin
        check("fwd_block", rx.out_block, (ptr < sent.size()) ? sent[ptr] : 'x);
        ptr++;
      end
    end
    if (lock_prev && !rx.out_block_lock) begin
      nfalls++;
      fall_blk   = rx.out_block;
      fall_valid = rx.out_valid;
      fall_slip  = rx.out_slip_cnt;
    end
    if (!rx.out_block_lock) ptr = -1;
    lock_prev = rx.out_block_lock;
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) drive(pct);
  endtask

  task automatic start_stream();
    reset = 1'b1;
    rx.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bitq.delete();
    sent.delete();
    ptr = -1; exp_first = -1; nvalid = 0; nfalls = 0; lock_prev = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    bit ok;
    tbl[0] = '{2'b01, 64'h0,                  66'h0_0000_0000_0000_0001, 1'b1};
    tbl[1] = '{2'b10, 64'h1,                  66'h0_0000_0000_0000_0006, 1'b1};
    tbl[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFC, 1'b1};
    tbl[3] = '{2'b11, 64'h8000_0000_0000_0000, 66'h2_0000_0000_0000_0003, 1'b1};
    tbl[4] = '{2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 66'h2_9696_9696_9696_9695, 1'b1};
    tbl[5] = '{2'b10, 64'h0123_4567_89AB_CDEF, 66'h0_048D_159E_26AF_37BE, 1'b1};

    // Reset held while data is driven
    reset = 1'b1;
    rx.in_enable = 1'b1;
    rx.in_pma_ready = 1'b1;
    rx.in_valid = 1'b1;
    rx.in_data = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx.out_valid, 0);
    check("rst_block", rx.out_block, 0);
    check("rst_lock", rx.out_block_lock, 0);
    check("rst_slip", rx.out_slip_cnt, 0);

    // Aligned lock acquisition and throughput: 160 blocks in 330 words
    start_stream();
    exp_first = 64;
    for (int i = 0; i < 160; i++) push_block(HDR_DATA, 64'h0123_4567_89AB_CDEF);
    run(131, 100);
    check("lock_before_64th", rx.out_block_lock, 0);
    run(1, 100);
    check("lock_at_64th", rx.out_block_lock, 1);
    check("lock_blk_not_fwd", rx.out_valid, 0);
    run(2, 100);
    check("no_fwd_yet", nvalid, 0);
    run(1, 100);
    check("first_fwd_count", nvalid, 1);
    check("first_fwd_valid", rx.out_valid, 1);
    check("first_fwd_block", rx.out_block, 66'h0_048D_159E_26AF_37BD);
    run(330 - 135, 100);
    check("thru_fwd_count", nvalid, 96);
    check("thru_extracted", ptr, 160);
    check("thru_cnt_zero", dut.cnt_q, 0);

    // Table: mixed headers/payloads while locked
    for (int i = 0; i < 6; i++) push_block(tbl[i].hdr, tbl[i].pay);
    push_block(HDR_DATA, 64'h0);
    push_block(HDR_DATA, 64'h0);
    for (int i = 0; i < 6; i++) begin
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
        drive(100);
        ok = rx.out_valid;
      end
      check("tbl_valid", ok, 1);
      check("tbl_block", rx.out_block, tbl[i].exp_blk);
      check("tbl_lock", rx.out_block_lock, tbl[i].exp_lock);
    end

    // Header errors: 15 in window 1 keeps lock, 16 in window 2 drops it
    start_stream();
    exp_first = 64;
    for (int i = 0; i < 200; i++)
      push_block(((i >= 70 && i <= 84) || (i >= 130 && i <= 145)) ? 2'b00 :
                 (i[0] ? HDR_CTRL : HDR_DATA), {32'hC0DE_FACE, 32'(i)});
    run(264, 100);
    check("err15_lock", rx.out_block_lock, 1);
    check("err15_falls", nfalls, 0);
    check("err15_slip", rx.out_slip_cnt, 0);
    run(37, 100);
    check("err16_before", nfalls, 0);
    run(1, 100);
    check("err16_falls", nfalls, 1);
    check("err16_fwd", fall_valid, 1);
    check("err16_block", fall_blk, {32'hC0DE_FACE, 32'd145, 2'b00});
    check("err16_slip", fall_slip, 1);

    // Misaligned PRBS31 stream with 50% in_valid gaps
    start_stream();
    lfsr = 31'h2A5A_1C3F;
    for (int i = 0; i < 17; i++) bitq.push_back(prbs_bit());
    for (int i = 0; i < 900; i++) begin
      logic [63:0] p;
      for (int k = 0; k < 64; k++) p[k] = prbs_bit();
      push_block(prbs_bit() ? HDR_CTRL : HDR_DATA, p);
    end
    for (int c = 0; c < 3000 && !rx.out_block_lock; c++) drive(50);
    check("mis_lock", rx.out_block_lock, 1);
    check("mis_slip", rx.out_slip_cnt, 17);
    run(400, 50);
    check("mis_lock_held", rx.out_block_lock, 1);
    check("mis_fwd_seen", nvalid > 0, 1);

    // One-cycle PMA ready drop while locked
    s = rx.out_slip_cnt;
    rx.in_pma_ready = 1'b0;
    drive(0);
    rx.in_pma_ready = 1'b1;
    check("rdy_lock", rx.out_block_lock, 0);
    check("rdy_valid", rx.out_valid, 0);
    check("rdy_cnt", dut.cnt_q, 0);
    check("rdy_slip_held", rx.out_slip_cnt, 66'(s));
    for (int c = 0; c < 3000 && !rx.out_block_lock; c++) drive(100);
    check("relock", rx.out_block_lock, 1);
    run(3, 100);

    // Asynchronous reset between clock edges
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", rx.out_valid, 0);
    check("arst_block", rx.out_block, 0);
    check("arst_lock", rx.out_block_lock, 0);
    check("arst_slip", rx.out_slip_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
